// File: rtl/line_fill_32to1024.sv
// Assembles 32 consecutive 32-bit beats into one 1024-bit line, optionally
// starting at a chosen word slot and wrapping (critical-word-first).
module line_fill_32to1024 #(
  parameter bit WRAP_FILL = 1'b1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [4:0]    start_sel,
  input  logic          abort,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [31:0]   in_data,
  output logic          line_valid,
  input  logic          line_ready,
  output logic [1023:0] line_data,
  output logic [31:0]   word_mask
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    FULL = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [4:0]      ptr_q, ptr_d;
  logic [5:0]      beats_q, beats_d;
  logic [1023:0]   data_q, data_d;
  logic [31:0]     mask_q, mask_d;
  logic [9:0]      slotBase;
  logic            beatAccepted;

  assign slotBase     = {ptr_q, 5'b00000};
  assign beatAccepted = (state_q == FILL) && in_valid;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      ptr_q   <= 5'd0;
      beats_q <= 6'd0;
      data_q  <= '0;
      mask_q  <= 32'd0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      beats_q <= beats_d;
      data_q  <= data_d;
      mask_q  <= mask_d;
    end
  end

  // Abort outranks every other event in FILL and FULL, including a beat that
  // would otherwise be accepted in the same cycle.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    beats_d = beats_q;
    data_d  = data_q;
    mask_d  = mask_q;

    case (state_q)
      IDLE: begin
        if (start && !abort) begin
          state_d = FILL;
          ptr_d   = WRAP_FILL ? start_sel : 5'd0;
          beats_d = 6'd0;
          data_d  = '0;
          mask_d  = 32'd0;
        end
      end

      FILL: begin
        if (abort) begin
          state_d = IDLE;
          beats_d = 6'd0;
          mask_d  = 32'd0;
        end else if (beatAccepted) begin
          data_d[slotBase +: 32] = in_data;
          mask_d[ptr_q]          = 1'b1;
          ptr_d                  = ptr_q + 5'd1;
          beats_d                = beats_q + 6'd1;
          if (beats_q == 6'd31) begin
            state_d = FULL;
          end
        end
      end

      FULL: begin
        if (abort) begin
          state_d = IDLE;
          beats_d = 6'd0;
          mask_d  = 32'd0;
        end else if (line_ready) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign in_ready   = (state_q == FILL);
  assign line_valid = (state_q == FULL);
  assign line_data  = data_q;
  assign word_mask  = mask_q;

endmodule

// File: doc/line_fill_32to1024.md
LINE_FILL_32TO1024 -- requirements
Module: line_fill_32to1024

Interface
REQ-001 The block SHALL have parameter WRAP_FILL, default 1; 1 = fill starts at start_sel and wraps (critical-word-first), 0 = fill always starts at word 0.
REQ-002 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 start  input  1  begin a new 1024-bit line fill; sampled only in IDLE.
REQ-006 start_sel  input  5  first word slot of the fill; sampled with start.
REQ-007 abort  input  1  cancel the current fill or line and return to IDLE.
REQ-008 in_valid  input  1  in_data holds a valid 32-bit word.
REQ-009 in_ready  output  1  block accepts a word this cycle.
REQ-010 in_data  input  32  incoming word.
REQ-011 line_valid  output  1  assembled line is complete and presented.
REQ-012 line_ready  input  1  consumer takes the line.
REQ-013 line_data  output  1024  assembled line; word k occupies bits [32k+31:32k].
REQ-014 word_mask  output  32  bit k is set when slot k has been written in the current fill.

Function
REQ-015 The block SHALL implement states IDLE, FILL and FULL, with state, slot pointer, 6-bit beat counter, line_data and word_mask all registered.
REQ-016 In IDLE, in_ready and line_valid SHALL be 0.
REQ-017 In IDLE, start=1 with abort=0 SHALL, at the next clock edge:
  - enter FILL;
  - load the pointer with start_sel if WRAP_FILL=1, else with 0;
  - clear the beat counter, word_mask and line_data to 0.
REQ-018 In FILL, in_ready SHALL be 1.
REQ-019 A beat is accepted when in_valid=1 and in_ready=1; on each accepted beat the block SHALL:
  - write in_data into slot pointer;
  - set word_mask[pointer];
  - advance the pointer by 1 modulo 32 (31 wraps to 0);
  - increment the beat counter.
REQ-020 Cycles in FILL with in_valid=0 SHALL change no state.
REQ-021 Acceptance of the 32nd beat SHALL move the block to FULL, so line_valid=1 in the cycle after that beat and word_mask=32'hFFFFFFFF.
REQ-022 In FULL, in_ready SHALL be 0, and line_valid, line_data and word_mask SHALL be held stable until line_ready=1.
REQ-023 In FULL, line_ready=1 SHALL return the block to IDLE at the next clock edge; line_data SHALL retain its value in IDLE until the next start.
REQ-024 start SHALL be ignored in FILL and FULL.
REQ-025 in_valid SHALL be ignored outside FILL, and no data SHALL be written outside FILL.
REQ-026 abort=1 in FILL or FULL SHALL force IDLE at the next edge and clear word_mask and the beat counter; abort SHALL take priority over a simultaneous accepted beat, line_ready or start.
REQ-027 In IDLE, start and abort asserted together SHALL leave the block in IDLE.
REQ-028 In FULL, line_ready=1 together with start=1 SHALL return to IDLE only; a new fill needs start in a later IDLE cycle, giving one idle cycle between lines.
REQ-029 All outputs SHALL be driven from registers, with no combinational path from inputs to outputs except in_ready and line_valid, which decode the state register only.

Reset
REQ-030 Asserting reset SHALL immediately, without waiting for a clock edge, put the block in IDLE with:
  - pointer = 0, beat counter = 0;
  - in_ready = 0, line_valid = 0;
  - line_data = 0, word_mask = 0.
REQ-031 Reset asserted mid-FILL or in FULL SHALL discard the partial or complete line.
REQ-032 Operation SHALL resume on the first clock edge after reset deasserts, with start accepted from that edge.

Verification
REQ-033 Full fill: WRAP_FILL=1, start with start_sel=0, then 32 back-to-back beats with data = slot index -> line_valid=1 one cycle after beat 32; line_data[31:0]=0, line_data[1023:992]=31; word_mask=32'hFFFFFFFF.
REQ-034 Wrap fill: start_sel=30, beats A, B, C, ... -> A in slot 30, B in slot 31, C in slot 0; after 2 beats word_mask=32'hC0000000. With WRAP_FILL=0 and start_sel=30, A lands in slot 0.
REQ-035 Gapped fill: in_valid toggled 1,0,1,0,... over 64 cycles -> exactly 32 beats accepted; line_valid rises after the last accepted beat.
REQ-036 Backpressure: line_ready=0 for 10 cycles in FULL while in_valid=1 with new data -> line_valid, line_data and word_mask unchanged; in_ready=0 throughout; line_ready=1 -> IDLE next cycle.
REQ-037 Abort: abort after 5 beats (concurrent with beat 6) -> IDLE next cycle, beat 6 not written, word_mask=0, in_ready=0.
REQ-038 Reset mid-fill: reset asserted after 10 beats, between clock edges -> all outputs 0 immediately; start after deassertion begins a clean fill.
